// File: rtl/key_debounce_multi.sv
// +----------------------------------------------------------------------------+
// | key_debounce_multi: N-channel active-low key synchroniser and debouncer     |
// | with press/release/long-press/auto-repeat pulses.    Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_debounce_multi #(
   parameter int N_KEYS       = 2,
   parameter int DEBOUNCE_CYC = 1485000,
   parameter int HOLD_CYC     = 25000000,
   parameter int REPEAT_CYC   = 5000000,
   parameter int REPEAT_EN    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] keyin,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_rpt
);

   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int RW = $clog2(REPEAT_CYC + 1);

   localparam logic [DW-1:0] c_db_last   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] c_hold_last = HW'(HOLD_CYC - 1);
   localparam logic [HW-1:0] c_hold_sat  = HW'(HOLD_CYC);
   localparam logic [RW-1:0] c_rpt_last  = RW'(REPEAT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   logic [N_KEYS-1:0] sync1_q, sync1_d;
   logic [N_KEYS-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = keyin;
      sync2_d = sync1_q;
   end

   // Preset to released so a reset never looks like a key edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic [DW-1:0] dbc_q, dbc_d;
      logic [HW-1:0] hc_q, hc_d;
      logic [RW-1:0] rc_q, rc_d;
      state_t        state_q, state_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;
      logic          rpt_q, rpt_d;
      logic          key_s;
      logic          accept;

      always_comb begin
         key_s     = ~sync2_q[i];
         dbc_d     = '0;
         level_d   = level_q;
         accept    = 1'b0;
         if (key_s != level_q) begin
            if (dbc_q == c_db_last) begin
               level_d = key_s;
               accept  = 1'b1;
            end else begin
               dbc_d = dbc_q + 1'b1;
            end
         end
         press_d   = accept & key_s;
         release_d = accept & ~key_s;
      end

      // A release accepted this cycle overrides any long/repeat pulse due now.
      always_comb begin
         state_d = state_q;
         hc_d    = hc_q;
         rc_d    = rc_q;
         long_d  = 1'b0;
         rpt_d   = 1'b0;
         if (release_d) begin
            state_d = ST_IDLE;
            hc_d    = '0;
            rc_d    = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (press_d) begin
                     state_d = ST_HELD;
                     hc_d    = '0;
                  end
               end
               ST_HELD: begin
                  if (hc_q == c_hold_last) begin
                     long_d = 1'b1;
                     if (REPEAT_EN != 0) begin
                        state_d = ST_REPEAT;
                        rc_d    = '0;
                     end else begin
                        hc_d = c_hold_sat;
                     end
                  end else if (hc_q != c_hold_sat) begin
                     hc_d = hc_q + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rc_q == c_rpt_last) begin
                     rpt_d = 1'b1;
                     rc_d  = '0;
                  end else begin
                     rc_d = rc_q + 1'b1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dbc_q     <= '0;
            hc_q      <= '0;
            rc_q      <= '0;
            state_q   <= ST_IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
         end else begin
            dbc_q     <= dbc_d;
            hc_q      <= hc_d;
            rc_q      <= rc_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
      assign key_rpt[i]     = rpt_q;
   end

endmodule

`default_nettype wire
